// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Turns hazard-unit stall/flush requests into per-cycle front-end enables.
// A multi-cycle stall is latched on its first cycle and held to completion
// even after the request drops. A flush always wins and aborts any stall in
// progress. Two saturating counters record stall cycles and flush cycles for
// performance debug.
module pipeline_stall_ctrl #(
    parameter int STALL_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STALL_W-1:0] stall_req,
    input  logic               flush_req,
    output logic               pc_write_en,
    output logic               ifid_write_en,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               stall_active,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [STALL_W-1:0] rem_q, rem_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    // Enables and next state, zero-cycle latency from the requests.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        stall_active  = 1'b0;
        state_d       = state_q;
        rem_d         = rem_q;
        if (!rst_n) begin
            // Front end frozen with a bubble while reset is held.
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end else if (flush_req) begin
            // Flush has priority: redirect, squash IF/ID, drop any pending stall.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = IDLE;
            rem_d       = '0;
        end else if (state_q == STALL) begin
            // Holding a previously latched stall; new requests are ignored.
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            stall_active  = 1'b1;
            if (rem_q == STALL_W'(1)) begin
                state_d = IDLE;
                rem_d   = '0;
            end else begin
                rem_d = rem_q - 1'b1;
            end
        end else if (stall_req != '0) begin
            // First cycle of a new stall; remember what is left beyond this one.
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            stall_active  = 1'b1;
            if (stall_req != STALL_W'(1)) begin
                state_d = STALL;
                rem_d   = stall_req - 1'b1;
            end
        end
    end

    // State and remaining-cycle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_active) stall_cycles <= sat_inc(stall_cycles);
            if (flush_req)    flush_count  <= sat_inc(flush_count);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with 4-bit counters so saturation
// is reachable in a short run.
module tb_pipeline_stall_ctrl;

    localparam int STALL_W = 2;
    localparam int CNT_W   = 4;

    // {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall_active}
    localparam logic [4:0] FREE  = 5'b11000;
    localparam logic [4:0] HOLD  = 5'b00011;
    localparam logic [4:0] FLUSH = 5'b11110;
    localparam logic [4:0] RST   = 5'b00010;

    logic               clk;
    logic               rst_n;
    logic [STALL_W-1:0] stall_req;
    logic               flush_req;
    logic               pc_write_en;
    logic               ifid_write_en;
    logic               ifid_flush;
    logic               idex_bubble;
    logic               stall_active;
    logic [CNT_W-1:0]   stall_cycles;
    logic [CNT_W-1:0]   flush_count;

    int n_tests;
    int n_fail;

    pipeline_stall_ctrl #(.STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_req     (stall_req),
        .flush_req     (flush_req),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .stall_active  (stall_active),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall_active};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests (called just after a rising edge), check the
    // combinational enables mid-cycle, then advance past the next rising edge.
    task automatic cyc(input logic [STALL_W-1:0] sr, input logic fr,
                       input logic [4:0] exp, input string tag);
        stall_req = sr;
        flush_req = fr;
        @(negedge clk);
        chk(tag, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        stall_req = '0;
        flush_req = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_outs", 32'(outs()), 32'(RST));
        chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_flush_cnt", 32'(flush_count), 32'd0);
        rst_n = 1'b1;
        cyc(2'd0, 1'b0, FREE, "idle_free");

        // Single-cycle stall
        cyc(2'd1, 1'b0, HOLD, "s1_hold");
        cyc(2'd0, 1'b0, FREE, "s1_free");
        chk("s1_cnt", 32'(stall_cycles), 32'd1);

        // Two-cycle stall from a one-cycle request
        cyc(2'd2, 1'b0, HOLD, "s2_hold0");
        cyc(2'd0, 1'b0, HOLD, "s2_hold1");
        cyc(2'd0, 1'b0, FREE, "s2_free");
        chk("s2_cnt", 32'(stall_cycles), 32'd3);

        // Three-cycle stall; requests during the hold are ignored
        cyc(2'd3, 1'b0, HOLD, "s3_hold0");
        cyc(2'd3, 1'b0, HOLD, "s3_hold1");
        cyc(2'd1, 1'b0, HOLD, "s3_hold2");
        cyc(2'd0, 1'b0, FREE, "s3_free");
        chk("s3_cnt", 32'(stall_cycles), 32'd6);

        // Flush aborts a stall in its second cycle
        cyc(2'd2, 1'b0, HOLD,  "ab_hold");
        cyc(2'd0, 1'b1, FLUSH, "ab_flush");
        cyc(2'd0, 1'b0, FREE,  "ab_free");
        chk("ab_stall_cnt", 32'(stall_cycles), 32'd7);
        chk("ab_flush_cnt", 32'(flush_count), 32'd1);

        // Flush and stall together in IDLE: flush wins, nothing follows
        cyc(2'd2, 1'b1, FLUSH, "fs_flush");
        cyc(2'd0, 1'b0, FREE,  "fs_free");
        chk("fs_flush_cnt", 32'(flush_count), 32'd2);
        chk("fs_stall_cnt", 32'(stall_cycles), 32'd7);

        // Back-to-back single stalls re-sample fresh each cycle
        cyc(2'd1, 1'b0, HOLD, "bb_hold0");
        cyc(2'd1, 1'b0, HOLD, "bb_hold1");
        cyc(2'd0, 1'b0, FREE, "bb_free");
        chk("bb_cnt", 32'(stall_cycles), 32'd9);

        // Saturation of both counters
        for (int i = 0; i < 20; i++) cyc(2'd1, 1'b0, HOLD, "sat_hold");
        chk("sat_stall_cnt", 32'(stall_cycles), 32'd15);
        for (int i = 0; i < 15; i++) cyc(2'd0, 1'b1, FLUSH, "sat_flush");
        chk("sat_flush_cnt", 32'(flush_count), 32'd15);

        // Reset in the middle of a long stall
        cyc(2'd3, 1'b0, HOLD, "mr_hold");
        stall_req = '0;
        rst_n     = 1'b0;
        #1;
        chk("mr_outs", 32'(outs()), 32'(RST));
        chk("mr_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("mr_flush_cnt", 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2'd0, 1'b0, FREE, "mr_free");
        chk("mr_cnt_after", 32'(stall_cycles), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
